sar_search_cmp: RTL and testbench
=================================

// Module: sar_search_cmp
// PURPOSE
//  Successive-approximation search controller: the initiator side of the magnitude-comparator interface.
//  - Drives a trial word into an external WIDTH-bit comparator (trial on its a input, target on b).
//  - Reads back the gt/lt/eq flags and binary-searches, MSB first, for the value equal to target.
//  - Sits in front of the chap6 comparator; used for threshold and code search.
// PARAMETERS
//  WIDTH   4   width of trial, result and the compared words
// PORTS
//  clk      in   1      rising-edge clock
//  rst_n    in   1      asynchronous active-low reset
//  start    in   1      request a search; sampled only in IDLE
//  cmp_gt   in   1      comparator flag: trial > target (combinational on trial)
//  cmp_lt   in   1      comparator flag: trial < target
//  cmp_eq   in   1      comparator flag: trial == target
//  trial    out  WIDTH  registered word driven to comparator input a
//  busy     out  1      high in TEST and CHECK
//  done     out  1      1-cycle pulse when the search ends
//  result   out  WIDTH  final value; held until the next accepted start
//  found    out  1      result equals target; held with result
//  err      out  1      flags were not one-hot during the search; held with result
// BEHAVIOUR
//  Interface and reset
//  - Single clock domain; reset is asynchronous, active-low (rst_n).
//  - On reset assertion, all outputs go to 0 and state goes to IDLE, including mid-search.
//  States: IDLE, TEST, CHECK, DONE. Internal bit index k counts WIDTH-1 down to 0.
//  IDLE
//  - start=1 at an edge: trial<=1<<(WIDTH-1), k<=WIDTH-1; clear result/found/err; go TEST.
//  - start=0: remain in IDLE.
//  TEST (one cycle per bit)
//  - Flags are sampled at the closing edge.
//  - cmp_eq: result<=trial, found<=1; go DONE (early exit).
//  - cmp_gt: clear bit k of trial.
//  - cmp_lt: keep bit k of trial.
//  - If gt or lt and k>0: also set bit k-1; k<=k-1; stay in TEST.
//  - If gt or lt and k==0: go CHECK; trial now holds the decided word.
//  CHECK
//  - Samples flags on the decided trial: result<=trial, found<=cmp_eq; go DONE.
//  - Needed for target==0, where every TEST trial reports gt.
//  Flag errors
//  - Any TEST/CHECK sample where {gt,lt,eq} is not one-hot: err<=1, found<=0, result<=trial; go DONE.
//  DONE
//  - done=1 and busy=0 for exactly one cycle; trial keeps its last value; go IDLE.
//  - start is ignored in DONE.
//  Busy and start
//  - busy is registered; it is high from the cycle after start is accepted until DONE.
//  - start is ignored while busy.
//  Latency (edge 0 = start accepted)
//  - Without early match: done is high in cycle WIDTH+2.
//  - With a match at the j-th trial (j=1..WIDTH): done is high in cycle j+1.
//  - The next start is accepted no earlier than the cycle after done.
//  Width rules
//  - trial and result are plain WIDTH-bit registers; no arithmetic and no wrap.
//  - target is the full range 0..2^WIDTH-1.
// TESTING (WIDTH=4; bench models the comparator behaviourally on trial vs target)
//  1 target=1011 -> trials 1000,1100,1010,1011; done in cycle 5; result=1011, found=1, err=0
//  2 target=0000 -> trials 1000,0100,0010,0001, CHECK 0000; done in cycle 6; result=0000, found=1
//  3 target=1000 -> first trial eq; done in cycle 2; target=1111 -> trials 1000..1111, done in cycle 5; found=1
//  4 bench forces gt=lt=1 on the 2nd trial -> done in cycle 3; err=1, found=0
//  5 start pulsed while busy -> ignored; rst_n low in cycle 2 -> all outputs 0 at once, IDLE; a new search then completes normally
//  6 sweep all 16 targets back to back -> result==target, found=1, exactly one done pulse per search

Source files
------------

// File: rtl/sar_search_cmp_if.sv
// Bundle between the SAR search controller (master) and the magnitude comparator
// plus the requester that starts a search and reads the result (slave).
interface sar_search_cmp_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic             cmp_gt;
    logic             cmp_lt;
    logic             cmp_eq;
    logic [WIDTH-1:0] trial;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             found;
    logic             err;

    modport master (
        input  start, cmp_gt, cmp_lt, cmp_eq,
        output trial, busy, done, result, found, err
    );

    modport slave (
        output start, cmp_gt, cmp_lt, cmp_eq,
        input  trial, busy, done, result, found, err
    );
endinterface

// File: rtl/sar_search_cmp.sv
// Successive-approximation search: drives trial words into an external comparator
// and binary-searches MSB first for the word equal to the comparator's target.
module sar_search_cmp #(
    parameter int WIDTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    sar_search_cmp_if.master  bus
);
    localparam int KW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [KW-1:0] K_ONE = KW'(1);
    localparam logic [KW-1:0] K_MSB = KW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_TEST,
        S_CHECK,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic [WIDTH-1:0] trial_q, trial_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             found_q, found_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             flags_ok;

    assign flags_ok = $onehot({bus.cmp_gt, bus.cmp_lt, bus.cmp_eq});

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no path
        // through the case below can leave one unassigned and infer a latch.
        state_d  = state_q;
        k_d      = k_q;
        trial_d  = trial_q;
        result_d = result_q;
        found_d  = found_q;
        err_d    = err_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    trial_d            = '0;
                    trial_d[WIDTH-1]   = 1'b1;
                    k_d                = K_MSB;
                    result_d           = '0;
                    found_d            = 1'b0;
                    err_d              = 1'b0;
                    state_d            = S_TEST;
                end
            end

            S_TEST: begin
                if (!flags_ok) begin
                    err_d    = 1'b1;
                    found_d  = 1'b0;
                    result_d = trial_q;
                    state_d  = S_DONE;
                end else if (bus.cmp_eq) begin
                    result_d = trial_q;
                    found_d  = 1'b1;
                    state_d  = S_DONE;
                end else begin
                    // Trial too big drops bit k; too small keeps it.
                    trial_d[k_q] = ~bus.cmp_gt;
                    if (k_q != '0) begin
                        trial_d[k_q - K_ONE] = 1'b1;
                        k_d                  = k_q - K_ONE;
                    end else begin
                        state_d = S_CHECK;
                    end
                end
            end

            // The decided word has never been compared itself (e.g. target 0).
            S_CHECK: begin
                result_d = trial_q;
                if (!flags_ok) begin
                    err_d   = 1'b1;
                    found_d = 1'b0;
                end else begin
                    found_d = bus.cmp_eq;
                end
                state_d = S_DONE;
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_TEST) || (state_d == S_CHECK);
        done_d = (state_d == S_DONE);
    end

    // NOTE: every register here is control or datapath state that must be clean
    // immediately on reset, so all of them sit on the asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            k_q      <= '0;
            trial_q  <= '0;
            result_q <= '0;
            found_q  <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every register samples the values
            // from before this edge, independent of statement order.
            state_q  <= state_d;
            k_q      <= k_d;
            trial_q  <= trial_d;
            result_q <= result_d;
            found_q  <= found_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.trial  = trial_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.found  = found_q;
    assign bus.err    = err_q;
endmodule

// File: tb/tb_sar_search_cmp.sv
// Directed bench for sar_search_cmp: behavioural comparator on trial vs target,
// scoreboard of expected trials and results, immediate-assertion checks.
module tb_sar_search_cmp;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sar_search_cmp_if #(.WIDTH(W)) bus ();

    sar_search_cmp #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [W-1:0] target = '0;
    bit           bad    = 1'b0;

    // Comparator model; 'bad' injects an illegal gt=lt=1 flag pattern.
    always_comb begin
        if (bad) begin
            bus.cmp_gt = 1'b1;
            bus.cmp_lt = 1'b1;
            bus.cmp_eq = 1'b0;
        end else begin
            bus.cmp_gt = (bus.trial > target);
            bus.cmp_lt = (bus.trial < target);
            bus.cmp_eq = (bus.trial == target);
        end
    end

    typedef struct {
        logic [W-1:0] result;
        logic         found;
        logic         err;
        int           done_cyc;
    } exp_t;

    exp_t         sb[$];
    logic [W-1:0] trq[$];
    int           n_cmp = 0;
    int           n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected trial sequence: decided high bits equal the target's, bit k set.
    task automatic build_expect(input logic [W-1:0] tgt, input bit bad_at2, output exp_t e);
        int t;
        int j;
        j = 0;
        for (int k = W - 1; k >= 0; k--) begin
            t = (int'(tgt) & ~((1 << (k + 1)) - 1)) | (1 << k);
            j++;
            trq.push_back(W'(t));
            if (bad_at2 && j == 2) begin
                e.result = W'(t); e.found = 1'b0; e.err = 1'b1; e.done_cyc = j + 1;
                return;
            end
            if (t == int'(tgt)) begin
                e.result = W'(t); e.found = 1'b1; e.err = 1'b0; e.done_cyc = j + 1;
                return;
            end
        end
        trq.push_back(tgt);
        e.result = tgt; e.found = 1'b1; e.err = 1'b0; e.done_cyc = W + 2;
    endtask

    task automatic run_search(input logic [W-1:0] tgt, input bit bad_at2, input bit poke);
        exp_t e;
        int   cyc;
        target = tgt;
        build_expect(tgt, bad_at2, e);
        sb.push_back(e);
        @(negedge clk) bus.start = 1'b1;
        @(negedge clk) bus.start = 1'b0;
        cyc = 1;
        while (bus.done !== 1'b1 && cyc < 20) begin
            check("busy_in_search", bus.busy, 1);
            check("trial_expected", trq.size() > 0, 1);
            if (trq.size() > 0) check("trial", bus.trial, trq.pop_front());
            if (bad_at2 && cyc == 2) bad = 1'b1;
            bus.start = (poke && cyc == 1);
            @(negedge clk);
            bad = 1'b0;
            cyc++;
        end
        e = sb.pop_front();
        check("done_seen", bus.done, 1);
        check("done_cycle", cyc, e.done_cyc);
        check("busy_at_done", bus.busy, 0);
        check("result", bus.result, e.result);
        check("found", bus.found, e.found);
        check("err", bus.err, e.err);
        check("trials_left", trq.size(), 0);
        trq.delete();
        if (poke) bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("done_one_pulse", bus.done, 0);
        check("idle_after_done", bus.busy, 0);
        check("result_held", bus.result, e.result);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.start = 1'b0;

        // Reset state
        #12;
        check("rst_trial", bus.trial, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_result", bus.result, 0);
        check("rst_found", bus.found, 0);
        check("rst_err", bus.err, 0);
        @(negedge clk) rst_n = 1'b1;

        // Directed searches
        run_search(4'b1011, 1'b0, 1'b0);
        run_search(4'b0000, 1'b0, 1'b0);
        run_search(4'b1000, 1'b0, 1'b0);
        run_search(4'b1111, 1'b0, 1'b0);
        run_search(4'b0110, 1'b1, 1'b0);

        // Start while busy and during DONE is ignored
        run_search(4'b0101, 1'b0, 1'b1);

        // Asynchronous reset mid-search
        target = 4'b1011;
        @(negedge clk) bus.start = 1'b1;
        @(negedge clk) bus.start = 1'b0;
        @(negedge clk);
        check("pre_rst_busy", bus.busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_trial", bus.trial, 0);
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_done", bus.done, 0);
        check("mid_rst_result", bus.result, 0);
        check("mid_rst_found", bus.found, 0);
        check("mid_rst_err", bus.err, 0);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_idle", bus.busy, 0);
        run_search(4'b0011, 1'b0, 1'b0);

        // Sweep every target
        for (int t = 0; t < (1 << W); t++) run_search(W'(t), 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
